io_bus_master: RTL and testbench
================================

Name: io_bus_master

Overview:
- Initiator side of the shared peripheral register bus (data_io / cs_en / wt_en / rd_en / 4-bit register address).
- Sits between the CPU load/store unit and the memory-mapped IO devices, such as the hard timers.
- Accepts one word request at a time over a valid/ready handshake.
- Decodes the target device, sequences a SETUP/ACCESS bus cycle, and returns read data or an error response.

Parameters:
N_DEV, 4, number of device slots; one cs_en/wt_en/rd_en bit per slot
DEV_SHIFT, 8, LSB position of the 4-bit device index field in req_addr
ACCESS_CYCLES, 1, length of the ACCESS phase in clocks (1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  CPU request valid
req_ready  output  1  master idle, request accepted when req_valid && req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  32  byte address; [DEV_SHIFT+3:DEV_SHIFT] = device index, [5:2] = register address
req_wdata  input  32  write data
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  read data, valid with resp_valid
resp_err  output  1  decode error, valid with resp_valid
data_io  inout  32  shared bidirectional bus data
cs_en  output  N_DEV  one-hot device select
wt_en  output  N_DEV  per-device write strobe, only ever set together with the same cs_en bit
rd_en  output  N_DEV  per-device read strobe, only ever set together with the same cs_en bit
addr_out  output  4  register address (req_addr[5:2])

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; cs_en/wt_en/rd_en=0; addr_out=4'hf; data_io released (high-Z).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1; all bus strobes 0.
  - On acceptance, latch write flag, address, wdata and device index.
  - Device index < N_DEV: go to SETUP.
  - Otherwise: go to RESP with err=1; no bus activity at all.
- SETUP (1 cycle):
  - cs_en[idx]=1; addr_out driven; wt_en=rd_en=0.
  - For writes, data_io is driven with the latched wdata; for reads it is released.
- ACCESS (ACCESS_CYCLES cycles, counted by a 4-bit down-counter):
  - cs_en and addr_out held.
  - Write: data_io driven for the whole phase; wt_en[idx]=1 only in the final ACCESS cycle, giving exactly one write edge per request.
  - Read: rd_en[idx]=1 for the whole phase; data_io is sampled into resp_rdata at the final ACCESS clock edge.
  - Then go to RESP.
- RESP (1 cycle):
  - resp_valid=1; all bus strobes 0; data_io released; addr_out=4'hf.
  - resp_rdata = sampled value for reads, 0 for writes and errors.
  - resp_err as latched.
  - Next state: IDLE.
- Latency, request accept to resp_valid:
  - Valid device: 2+ACCESS_CYCLES clocks (3 at default).
  - Error: 1 clock.
- Back-to-back: req_ready is 0 in SETUP/ACCESS/RESP. The earliest next acceptance is the cycle after RESP. Inputs are ignored while req_ready=0.
- Bus turnaround: data_io is never driven in IDLE or RESP, so there is at least one released cycle between any write and a following read.
- Read of an unmapped register inside a valid device returns whatever the device drives (its own decode, typically 0); the master does not flag it.
- Reset mid-operation: all strobes drop and data_io releases immediately (asynchronously). No response is issued for the aborted request.
- Request signals are latched at acceptance; later changes to req_* do not affect the transfer in flight.

Test Plan:
- Reset: hold rst_n=0 -> req_ready=1, cs_en=0, wt_en=0, rd_en=0, data_io=Z, addr_out=4'hf, resp_valid=0.
- Write: write 0x0000_1234 to req_addr=0x0000_0100 (dev 1, reg 0) -> SETUP cs_en=4'b0010, addr_out=0, data_io=0x1234; next cycle wt_en=4'b0010 for exactly 1 clk; resp_valid at accept+3, resp_err=0, resp_rdata=0.
- Read: device 1 model drives 0xDEAD_BEEF on reg 0xf -> read req_addr=0x0000_013C gives rd_en=4'b0010, resp_rdata=0xDEADBEEF, resp_err=0, data_io never driven by the master.
- Decode error: read req_addr=0x0000_0500 with N_DEV=4 -> resp_valid 1 clk after accept, resp_err=1, resp_rdata=0; cs_en/wt_en/rd_en stay 0 throughout.
- ACCESS_CYCLES=3, write -> cs_en held 4 clks, wt_en high only on the 4th, resp at accept+5; back-to-back read is accepted the cycle after RESP.
- Reset mid-ACCESS: assert rst_n=0 during a write's ACCESS -> strobes 0 and data_io Z before the next edge, no resp_valid; the device register is unchanged.

Source files
------------

// File: rtl/io_bus_master.sv
// Initiator for the shared peripheral register bus: decodes the device, runs SETUP/ACCESS, returns a response.
// Latency: 2+ACCESS_CYCLES clocks from request accept to resp_valid for a mapped device; 1 clock for a decode error.
// Backpressure: one request in flight; req_ready is low from accept until the cycle after the response pulse.
module io_bus_master #(
    parameter int N_DEV         = 4,
    parameter int DEV_SHIFT     = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    inout  wire  [31:0]      data_io,
    output logic [N_DEV-1:0] cs_en,
    output logic [N_DEV-1:0] wt_en,
    output logic [N_DEV-1:0] rd_en,
    output logic [3:0]       addr_out
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [3:0] ACC_LEN = 4'(ACCESS_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic        write_q;
    logic        drive_en;
    logic [31:0] wdata_q;

    logic [3:0]       req_idx;
    logic             idx_ok;
    logic [N_DEV-1:0] req_sel;
    logic             unused_addr;

    assign req_idx     = req_addr[DEV_SHIFT+3:DEV_SHIFT];
    assign idx_ok      = ({1'b0, req_idx} < 5'(N_DEV));
    assign req_sel     = N_DEV'(1) << req_idx;
    // Only the device index and word-address fields are decoded.
    assign unused_addr = ^req_addr;

    // The master only drives the shared data bus while a write is in SETUP/ACCESS.
    assign data_io = drive_en ? wdata_q : 'z;

    // Bus cycle sequencer; every bus and response output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            cs_en      <= '0;
            wt_en      <= '0;
            rd_en      <= '0;
            addr_out   <= 4'hf;
            drive_en   <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        if (idx_ok) begin
                            state    <= SETUP;
                            cs_en    <= req_sel;
                            addr_out <= req_addr[5:2];
                            drive_en <= req_write;
                        end else begin
                            // Unmapped device: answer straight away, never touch the bus.
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    cnt   <= ACC_LEN;
                    if (write_q) begin
                        // Write strobe lands only in the last ACCESS cycle.
                        if (ACC_LEN == 4'd1) wt_en <= cs_en;
                    end else begin
                        rd_en <= cs_en;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd1) begin
                        state      <= RESP;
                        cs_en      <= '0;
                        wt_en      <= '0;
                        rd_en      <= '0;
                        drive_en   <= 1'b0;
                        addr_out   <= 4'hf;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= write_q ? 32'h0 : data_io;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (write_q && cnt == 4'd2) wt_en <= cs_en;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: two instances (ACCESS_CYCLES=1 on bus a, 3 on bus b) each with a device-1 register model.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: requests presented while req_ready is low must be ignored.
module tb_io_bus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic dev_clear;
    int   vectors     = 0;
    int   miscompares = 0;

    logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic [3:0]  a_cs_en, a_wt_en, a_rd_en, a_addr_out;
    wire  [31:0] a_data_io;

    logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic [3:0]  b_cs_en, b_wt_en, b_rd_en, b_addr_out;
    wire  [31:0] b_data_io;

    logic [31:0] a_regs [16];
    logic [31:0] b_regs [16];

    io_bus_master #(.N_DEV(4), .DEV_SHIFT(8), .ACCESS_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .data_io(a_data_io), .cs_en(a_cs_en), .wt_en(a_wt_en), .rd_en(a_rd_en),
        .addr_out(a_addr_out)
    );

    io_bus_master #(.N_DEV(4), .DEV_SHIFT(8), .ACCESS_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .data_io(b_data_io), .cs_en(b_cs_en), .wt_en(b_wt_en), .rd_en(b_rd_en),
        .addr_out(b_addr_out)
    );

    // Weak pull so a released bus reads as all ones.
    assign (pull0, pull1) a_data_io = '1;
    assign (pull0, pull1) b_data_io = '1;

    // Device 1 drives its register onto the bus while selected for read.
    assign a_data_io = (a_cs_en[1] && a_rd_en[1]) ? a_regs[a_addr_out] : 'z;
    assign b_data_io = (b_cs_en[1] && b_rd_en[1]) ? b_regs[b_addr_out] : 'z;

    // Device 1 register files: preload, then capture on the write strobe edge.
    always @(posedge clk) begin
        if (dev_clear) begin
            for (int i = 0; i < 16; i++) begin
                a_regs[i] <= (i == 15) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(i));
                b_regs[i] <= (i == 15) ? 32'hDEAD_BEEF : (32'h1000_0000 | 32'(i));
            end
        end else begin
            if (a_cs_en[1] && a_wt_en[1]) a_regs[a_addr_out] <= a_data_io;
            if (b_cs_en[1] && b_wt_en[1]) b_regs[b_addr_out] <= b_data_io;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        dev_clear = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        tick; tick;
        vectors++;
        if ({a_req_ready, a_resp_valid, a_resp_err, a_cs_en, a_wt_en, a_rd_en, a_addr_out} !== {3'b100, 12'h000, 4'hf}) begin
            $display("FAIL reset_ctrl_a: got %b expected %b",
                     {a_req_ready, a_resp_valid, a_resp_err, a_cs_en, a_wt_en, a_rd_en, a_addr_out}, {3'b100, 12'h000, 4'hf});
            miscompares++;
        end
        vectors++;
        if ({a_data_io, a_resp_rdata} !== {32'hFFFF_FFFF, 32'h0}) begin
            $display("FAIL reset_data_a: got %h expected %h", {a_data_io, a_resp_rdata}, {32'hFFFF_FFFF, 32'h0});
            miscompares++;
        end
        vectors++;
        if ({b_req_ready, b_resp_valid, b_cs_en, b_wt_en, b_rd_en, b_addr_out, b_data_io} !== {2'b10, 12'h000, 4'hf, 32'hFFFF_FFFF}) begin
            $display("FAIL reset_b: got %h expected %h",
                     {b_req_ready, b_resp_valid, b_cs_en, b_wt_en, b_rd_en, b_addr_out, b_data_io}, {2'b10, 12'h000, 4'hf, 32'hFFFF_FFFF});
            miscompares++;
        end
        rst_n = 1'b1;
        tick;
        dev_clear = 1'b0;
        tick;
    endtask

    task automatic test_write;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h0000_0100; a_req_wdata = 32'h0000_1234;
        vectors++;
        if (a_req_ready !== 1'b1) begin
            $display("FAIL write_ready: got %b expected 1", a_req_ready);
            miscompares++;
        end
        tick; // SETUP
        a_req_valid = 1'b0; a_req_addr = 32'h0000_0FFC; a_req_wdata = 32'hFFFF_0000;
        vectors++;
        if ({a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io, a_req_ready, a_resp_valid} !== {4'b0010, 4'b0, 4'b0, 4'h0, 32'h0000_1234, 2'b00}) begin
            $display("FAIL write_setup: got %h expected %h",
                     {a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io, a_req_ready, a_resp_valid},
                     {4'b0010, 4'b0, 4'b0, 4'h0, 32'h0000_1234, 2'b00});
            miscompares++;
        end
        tick; // ACCESS
        vectors++;
        if ({a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io, a_resp_valid} !== {4'b0010, 4'b0010, 4'b0, 4'h0, 32'h0000_1234, 1'b0}) begin
            $display("FAIL write_access: got %h expected %h",
                     {a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io, a_resp_valid},
                     {4'b0010, 4'b0010, 4'b0, 4'h0, 32'h0000_1234, 1'b0});
            miscompares++;
        end
        tick; // RESP
        vectors++;
        if ({a_resp_valid, a_resp_err, a_req_ready, a_resp_rdata, a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io} !==
            {3'b100, 32'h0, 12'h000, 4'hf, 32'hFFFF_FFFF}) begin
            $display("FAIL write_resp: got %h expected %h",
                     {a_resp_valid, a_resp_err, a_req_ready, a_resp_rdata, a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io},
                     {3'b100, 32'h0, 12'h000, 4'hf, 32'hFFFF_FFFF});
            miscompares++;
        end
        tick; // IDLE
        vectors++;
        if ({a_resp_valid, a_req_ready, a_regs[0]} !== {2'b01, 32'h0000_1234}) begin
            $display("FAIL write_done: got %h expected %h", {a_resp_valid, a_req_ready, a_regs[0]}, {2'b01, 32'h0000_1234});
            miscompares++;
        end
    endtask

    task automatic test_read;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h0000_013C; a_req_wdata = 32'h0000_FFFF;
        tick; // SETUP
        a_req_valid = 1'b0;
        vectors++;
        if ({a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io} !== {4'b0010, 4'b0, 4'b0, 4'hf, 32'hFFFF_FFFF}) begin
            $display("FAIL read_setup: got %h expected %h",
                     {a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io}, {4'b0010, 4'b0, 4'b0, 4'hf, 32'hFFFF_FFFF});
            miscompares++;
        end
        tick; // ACCESS
        vectors++;
        if ({a_cs_en, a_wt_en, a_rd_en, a_data_io} !== {4'b0010, 4'b0, 4'b0010, 32'hDEAD_BEEF}) begin
            $display("FAIL read_access: got %h expected %h",
                     {a_cs_en, a_wt_en, a_rd_en, a_data_io}, {4'b0010, 4'b0, 4'b0010, 32'hDEAD_BEEF});
            miscompares++;
        end
        tick; // RESP
        vectors++;
        if ({a_resp_valid, a_resp_err, a_resp_rdata, a_cs_en, a_rd_en} !== {2'b10, 32'hDEAD_BEEF, 8'h00}) begin
            $display("FAIL read_resp: got %h expected %h",
                     {a_resp_valid, a_resp_err, a_resp_rdata, a_cs_en, a_rd_en}, {2'b10, 32'hDEAD_BEEF, 8'h00});
            miscompares++;
        end
        tick;
    endtask

    task automatic test_decode_error;
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h0000_0500; a_req_wdata = 32'h0;
        tick; // RESP
        a_req_valid = 1'b0;
        vectors++;
        if ({a_resp_valid, a_resp_err, a_req_ready, a_resp_rdata} !== {3'b110, 32'h0}) begin
            $display("FAIL err_resp: got %h expected %h", {a_resp_valid, a_resp_err, a_req_ready, a_resp_rdata}, {3'b110, 32'h0});
            miscompares++;
        end
        vectors++;
        if ({a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io} !== {12'h000, 4'hf, 32'hFFFF_FFFF}) begin
            $display("FAIL err_bus: got %h expected %h", {a_cs_en, a_wt_en, a_rd_en, a_addr_out, a_data_io}, {12'h000, 4'hf, 32'hFFFF_FFFF});
            miscompares++;
        end
        tick; // IDLE
        vectors++;
        if ({a_resp_valid, a_req_ready, a_cs_en, a_wt_en, a_rd_en} !== {2'b01, 12'h000}) begin
            $display("FAIL err_idle: got %h expected %h", {a_resp_valid, a_req_ready, a_cs_en, a_wt_en, a_rd_en}, {2'b01, 12'h000});
            miscompares++;
        end
    endtask

    task automatic test_back_to_back;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_0108; b_req_wdata = 32'hCAFE_0002;
        tick;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if ({b_cs_en, b_wt_en, b_addr_out, b_data_io, b_resp_valid} !== {4'b0010, ((k == 4) ? 4'b0010 : 4'b0000), 4'h2, 32'hCAFE_0002, 1'b0}) begin
                $display("FAIL long_write_c%0d: got %h expected %h", k, {b_cs_en, b_wt_en, b_addr_out, b_data_io, b_resp_valid},
                         {4'b0010, ((k == 4) ? 4'b0010 : 4'b0000), 4'h2, 32'hCAFE_0002, 1'b0});
                miscompares++;
            end
            tick;
        end
        // RESP cycle; the next request is presented now and must wait.
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h0000_0108; b_req_wdata = 32'h0;
        vectors++;
        if ({b_resp_valid, b_resp_err, b_req_ready, b_resp_rdata, b_cs_en} !== {3'b100, 32'h0, 4'h0}) begin
            $display("FAIL long_write_resp: got %h expected %h", {b_resp_valid, b_resp_err, b_req_ready, b_resp_rdata, b_cs_en}, {3'b100, 32'h0, 4'h0});
            miscompares++;
        end
        tick; // IDLE, read accepted at the next edge
        vectors++;
        if ({b_req_ready, b_resp_valid, b_cs_en, b_regs[2]} !== {2'b10, 4'h0, 32'hCAFE_0002}) begin
            $display("FAIL b2b_idle: got %h expected %h", {b_req_ready, b_resp_valid, b_cs_en, b_regs[2]}, {2'b10, 4'h0, 32'hCAFE_0002});
            miscompares++;
        end
        tick;
        b_req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            vectors++;
            if ({b_cs_en, b_wt_en, b_rd_en, b_resp_valid} !== {4'b0010, 4'b0000, ((k == 1) ? 4'b0000 : 4'b0010), 1'b0}) begin
                $display("FAIL b2b_read_c%0d: got %h expected %h", k, {b_cs_en, b_wt_en, b_rd_en, b_resp_valid},
                         {4'b0010, 4'b0000, ((k == 1) ? 4'b0000 : 4'b0010), 1'b0});
                miscompares++;
            end
            tick;
        end
        vectors++;
        if ({b_resp_valid, b_resp_err, b_resp_rdata} !== {2'b10, 32'hCAFE_0002}) begin
            $display("FAIL b2b_read_resp: got %h expected %h", {b_resp_valid, b_resp_err, b_resp_rdata}, {2'b10, 32'hCAFE_0002});
            miscompares++;
        end
        tick;
    endtask

    task automatic test_reset_mid_access;
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h0000_010C; b_req_wdata = 32'h1111_1111;
        tick; // SETUP
        b_req_valid = 1'b0;
        tick; // first ACCESS cycle
        vectors++;
        if ({b_cs_en, b_data_io} !== {4'b0010, 32'h1111_1111}) begin
            $display("FAIL abort_pre: got %h expected %h", {b_cs_en, b_data_io}, {4'b0010, 32'h1111_1111});
            miscompares++;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({b_cs_en, b_wt_en, b_rd_en, b_addr_out, b_data_io, b_req_ready, b_resp_valid} !== {12'h000, 4'hf, 32'hFFFF_FFFF, 2'b10}) begin
            $display("FAIL abort_async: got %h expected %h", {b_cs_en, b_wt_en, b_rd_en, b_addr_out, b_data_io, b_req_ready, b_resp_valid},
                     {12'h000, 4'hf, 32'hFFFF_FFFF, 2'b10});
            miscompares++;
        end
        tick; tick;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            vectors++;
            if ({b_resp_valid, b_wt_en, b_cs_en} !== 9'h000) begin
                $display("FAIL abort_quiet_c%0d: got %h expected 000", k, {b_resp_valid, b_wt_en, b_cs_en});
                miscompares++;
            end
        end
        vectors++;
        if (b_regs[3] !== 32'h1000_0003) begin
            $display("FAIL abort_reg: got %h expected %h", b_regs[3], 32'h1000_0003);
            miscompares++;
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_decode_error;
        test_back_to_back;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
